// File: rtl/akuma_pkg.sv
// Shared definitions for the Akuma character controller and the sprite selector
// downstream of it: screen geometry, action states and sprite codes.
package akuma_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // Internal signed width for position/velocity arithmetic (10-bit coords + sign + headroom)
  localparam int PW = 12;

  // State encodings are identical to the sprite codes, so the state register drives sprite directly
  typedef enum logic [2:0] {
    ST_STAND  = 3'd0,
    ST_PUNCH  = 3'd1,
    ST_JUMP   = 3'd2,
    ST_CROUCH = 3'd3,
    ST_WALK_L = 3'd4,
    ST_WALK_R = 3'd5,
    ST_DEATH  = 3'd6,
    ST_JATK   = 3'd7
  } akuma_state_t;

  localparam logic [2:0] SPR_STAND  = 3'd0;
  localparam logic [2:0] SPR_PUNCH  = 3'd1;
  localparam logic [2:0] SPR_JUMP   = 3'd2;
  localparam logic [2:0] SPR_CROUCH = 3'd3;
  localparam logic [2:0] SPR_WALK_L = 3'd4;
  localparam logic [2:0] SPR_WALK_R = 3'd5;
  localparam logic [2:0] SPR_DEATH  = 3'd6;
  localparam logic [2:0] SPR_JATK   = 3'd7;

  // Horizontal displacement for a drift of -1/0/+1 steps
  function automatic logic signed [PW-1:0] drift_dx(input logic signed [1:0] drift,
                                                    input int step);
    logic signed [PW-1:0] dx;
    dx = '0;
    if (drift == 2'sb01)      dx = PW'(step);
    else if (drift == 2'sb11) dx = PW'(-step);
    return dx;
  endfunction

endpackage

// File: rtl/akuma_physics.sv
// Combinational motion step: signed X/Y/vy update, landing detection and
// saturation of X to the legal screen range.
module akuma_physics
  import akuma_pkg::*;
#(
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 560,
  parameter int GROUND_Y = 300,
  parameter int GRAVITY  = 1
) (
  input  logic [9:0]           x,
  input  logic signed [PW-1:0] dx,
  input  logic [9:0]           y,
  input  logic signed [PW-1:0] vy,
  output logic [9:0]           x_next,
  output logic [9:0]           y_next,
  output logic signed [PW-1:0] vy_next,
  output logic                 landed
);

  localparam logic signed [PW-1:0] X_MIN_S  = PW'(X_MIN);
  localparam logic signed [PW-1:0] X_MAX_S  = PW'(X_MAX);
  localparam logic signed [PW-1:0] GROUND_S = PW'(GROUND_Y);
  localparam logic signed [PW-1:0] GRAV_S   = PW'(GRAVITY);

  logic signed [PW-1:0] x_sum;
  logic signed [PW-1:0] y_sum;

  // NOTE: every output gets a value on every path through this block, so no latches are inferred.
  always_comb begin
    x_sum = $signed({2'b00, x}) + dx;
    if (x_sum < X_MIN_S)      x_next = X_MIN_S[9:0];
    else if (x_sum > X_MAX_S) x_next = X_MAX_S[9:0];
    else                      x_next = x_sum[9:0];

    y_sum   = $signed({2'b00, y}) + vy;
    vy_next = vy + GRAV_S;
    // Only a falling (or apex) body can land; a rising one is still leaving the ground
    landed  = (y_sum >= GROUND_S) && !vy[PW-1];
    if (landed)              y_next = GROUND_S[9:0];
    else if (y_sum[PW-1])    y_next = '0;
    else                     y_next = y_sum[9:0];
  end

endmodule

// File: rtl/akuma_motion.sv
// Frame-rate action FSM for Akuma: samples control levels on frame_tick and
// holds registered position/sprite outputs stable for the whole frame.
module akuma_motion
  import akuma_pkg::*;
#(
  parameter int X_START      = 320,
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 560,
  parameter int GROUND_Y     = 300,
  parameter int WALK_STEP    = 2,
  parameter int JUMP_VEL     = 12,
  parameter int GRAVITY      = 1,
  parameter int PUNCH_FRAMES = 8
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_punch,
  input  logic       hp_zero,
  output logic [9:0] AkumaX,
  output logic [9:0] AkumaY,
  output logic [2:0] sprite,
  output logic       airborne
);

  localparam int CW = (PUNCH_FRAMES > 1) ? $clog2(PUNCH_FRAMES) : 1;
  localparam logic [CW-1:0]        PUNCH_LOAD = CW'(PUNCH_FRAMES - 1);
  localparam logic signed [PW-1:0] STEP_S     = PW'(WALK_STEP);
  localparam logic signed [PW-1:0] JUMP_VY    = PW'(-JUMP_VEL);

  akuma_state_t         state_q, state_d, g_state;
  logic [9:0]           x_q, x_d, y_q, y_d;
  logic signed [PW-1:0] vy_q, vy_d;
  logic signed [1:0]    drift_q, drift_d, key_drift;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 air_q, air_d;

  logic signed [PW-1:0] phys_dx, phys_vy, pvy;
  logic [9:0]           px, py;
  logic                 landed;

  // Ground-state decision, strongest key first; hp_zero is handled by the main FSM
  always_comb begin
    key_drift = 2'sb00;
    if (key_left && !key_right)      key_drift = 2'sb11;
    else if (key_right && !key_left) key_drift = 2'sb01;

    if (key_up)                      g_state = ST_JUMP;
    else if (key_punch)              g_state = ST_PUNCH;
    else if (key_down)               g_state = ST_CROUCH;
    else if (key_drift == 2'sb11)    g_state = ST_WALK_L;
    else if (key_drift == 2'sb01)    g_state = ST_WALK_R;
    else                             g_state = ST_STAND;
  end

  // Airborne bodies keep their stored drift/velocity; on the ground the pending decision selects the step
  always_comb begin
    phys_dx = '0;
    phys_vy = vy_q;
    if (air_q) begin
      phys_dx = drift_dx(drift_q, WALK_STEP);
    end else begin
      case (g_state)
        ST_JUMP: begin
          phys_dx = drift_dx(key_drift, WALK_STEP);
          phys_vy = JUMP_VY;
        end
        ST_WALK_L: phys_dx = -STEP_S;
        ST_WALK_R: phys_dx = STEP_S;
        default:   phys_dx = '0;
      endcase
    end
  end

  akuma_physics #(
    .X_MIN    (X_MIN),
    .X_MAX    (X_MAX),
    .GROUND_Y (GROUND_Y),
    .GRAVITY  (GRAVITY)
  ) u_physics (
    .x       (x_q),
    .dx      (phys_dx),
    .y       (y_q),
    .vy      (phys_vy),
    .x_next  (px),
    .y_next  (py),
    .vy_next (pvy),
    .landed  (landed)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    vy_d    = vy_q;
    drift_d = drift_q;
    cnt_d   = cnt_q;
    air_d   = air_q;

    if (air_q) begin
      // Ballistic motion continues through death; only punch may change the airborne action
      x_d  = px;
      y_d  = py;
      vy_d = pvy;
      if (landed) begin
        air_d   = 1'b0;
        vy_d    = '0;
        drift_d = 2'sb00;
        state_d = (hp_zero || state_q == ST_DEATH) ? ST_DEATH : ST_STAND;
      end else if (hp_zero || state_q == ST_DEATH) begin
        state_d = ST_DEATH;
      end else if (key_punch || state_q == ST_JATK) begin
        state_d = ST_JATK;
      end
    end else if (state_q == ST_DEATH) begin
      state_d = ST_DEATH;
    end else if (hp_zero) begin
      state_d = ST_DEATH;
    end else if (state_q == ST_PUNCH && cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end else begin
      state_d = g_state;
      x_d     = px;
      if (g_state == ST_JUMP) begin
        y_d     = py;
        vy_d    = pvy;
        drift_d = key_drift;
        air_d   = 1'b1;
      end
      if (g_state == ST_PUNCH) cnt_d = PUNCH_LOAD;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_STAND;
      x_q     <= 10'(X_START);
      y_q     <= 10'(GROUND_Y);
      vy_q    <= '0;
      drift_q <= 2'sb00;
      cnt_q   <= '0;
      air_q   <= 1'b0;
    end else if (frame_tick) begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      vy_q    <= vy_d;
      drift_q <= drift_d;
      cnt_q   <= cnt_d;
      air_q   <= air_d;
    end
  end

  assign AkumaX   = x_q;
  assign AkumaY   = y_q;
  assign sprite   = state_q;
  assign airborne = air_q;

endmodule

// File: tb/tb_akuma_motion.sv
// Self-checking bench for akuma_motion: a directed vector table for ground moves,
// then hand-written jump, jump-attack, death, reset and X-clamp sequences.
module tb_akuma_motion;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       key_left = 1'b0, key_right = 1'b0, key_up = 1'b0;
  logic       key_down = 1'b0, key_punch = 1'b0, hp_zero = 1'b0;
  logic [9:0] ax, ay, lo_x, lo_y, hi_x, hi_y;
  logic [2:0] spr, lo_spr, hi_spr;
  logic       air, lo_air, hi_air;

  always #5 Clk = ~Clk;

  akuma_motion u_dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick),
    .key_left(key_left), .key_right(key_right), .key_up(key_up),
    .key_down(key_down), .key_punch(key_punch), .hp_zero(hp_zero),
    .AkumaX(ax), .AkumaY(ay), .sprite(spr), .airborne(air)
  );

  akuma_motion #(.X_START(1)) u_lo (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick),
    .key_left(key_left), .key_right(key_right), .key_up(key_up),
    .key_down(key_down), .key_punch(key_punch), .hp_zero(hp_zero),
    .AkumaX(lo_x), .AkumaY(lo_y), .sprite(lo_spr), .airborne(lo_air)
  );

  akuma_motion #(.X_START(559)) u_hi (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick),
    .key_left(key_left), .key_right(key_right), .key_up(key_up),
    .key_down(key_down), .key_punch(key_punch), .hp_zero(hp_zero),
    .AkumaX(hi_x), .AkumaY(hi_y), .sprite(hi_spr), .airborne(hi_air)
  );

  // Key bit order: {hp_zero, punch, down, up, right, left}
  localparam logic [5:0] K_0 = 6'b000000;
  localparam logic [5:0] K_L = 6'b000001;
  localparam logic [5:0] K_R = 6'b000010;
  localparam logic [5:0] K_U = 6'b000100;
  localparam logic [5:0] K_D = 6'b001000;
  localparam logic [5:0] K_P = 6'b010000;
  localparam logic [5:0] K_H = 6'b100000;

  typedef struct {
    logic [5:0] keys;
    bit         tick;
    int         x;
    int         y;
    int         spr;
    int         air;
  } vec_t;

  vec_t vecs[20];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int x, input int y, input int s, input int a);
    check({tag, ".x"}, int'(ax), x);
    check({tag, ".y"}, int'(ay), y);
    check({tag, ".sprite"}, int'(spr), s);
    check({tag, ".air"}, int'(air), a);
  endtask

  // Y after k ticks of a fresh jump: 300 - sum of (12 - j) for j = 0..k-1
  function automatic int jump_y(input int k);
    return 300 - (12 * k - (k * (k - 1)) / 2);
  endfunction

  task automatic step(input logic [5:0] k, input bit tk);
    @(negedge Clk);
    {hp_zero, key_punch, key_down, key_up, key_right, key_left} = k;
    frame_tick = tk;
    @(posedge Clk);
    #1;
    frame_tick = 1'b0;
    if (!tk) begin
      repeat (2) @(posedge Clk);
      #1;
    end
  endtask

  task automatic reset_and_check(input string tag);
    @(negedge Clk);
    {hp_zero, key_punch, key_down, key_up, key_right, key_left} = K_0;
    #2 Reset_n = 1'b0;
    #1 check_all(tag, 320, 300, 0, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  initial begin
    vecs[0] = '{K_R, 1'b0, 320, 300, 0, 0};
    for (int i = 1; i <= 5; i++) vecs[i] = '{K_R, 1'b1, 320 + 2 * i, 300, 5, 0};
    vecs[6] = '{K_0, 1'b1, 330, 300, 0, 0};
    vecs[7] = '{K_P, 1'b1, 330, 300, 1, 0};
    for (int i = 8; i <= 14; i++) vecs[i] = '{K_L, 1'b1, 330, 300, 1, 0};
    vecs[15] = '{K_L, 1'b1, 328, 300, 4, 0};
    vecs[16] = '{K_D, 1'b1, 328, 300, 3, 0};
    vecs[17] = '{K_D | K_L, 1'b1, 328, 300, 3, 0};
    vecs[18] = '{K_L | K_R, 1'b1, 328, 300, 0, 0};
    vecs[19] = '{K_0, 1'b1, 328, 300, 0, 0};

    repeat (3) @(posedge Clk);
    #1 check_all("reset", 320, 300, 0, 0);
    @(negedge Clk);
    Reset_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      step(vecs[i].keys, vecs[i].tick);
      check_all($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].spr, vecs[i].air);
    end

    // Plain jump from rest: lands exactly on tick 25
    for (int k = 1; k <= 25; k++) begin
      step((k == 1) ? K_U : K_0, 1'b1);
      if (k < 25) check_all($sformatf("jump%0d", k), 328, jump_y(k), 2, 1);
      else        check_all("jump_land", 328, 300, 0, 0);
    end

    // Punch on tick 5 turns the jump into a sticky jump attack
    for (int k = 1; k <= 25; k++) begin
      step((k == 1) ? K_U : ((k == 5) ? K_P : K_0), 1'b1);
      if (k < 5)       check($sformatf("jatk%0d.sprite", k), int'(spr), 2);
      else if (k < 25) check($sformatf("jatk%0d.sprite", k), int'(spr), 7);
      else             check_all("jatk_land", 328, 300, 0, 0);
    end

    // Jump with left drift; held right is ignored while airborne
    for (int k = 1; k <= 25; k++) begin
      step((k == 1) ? (K_U | K_L) : K_R, 1'b1);
      check($sformatf("drift%0d.x", k), int'(ax), 328 - 2 * k);
      if (k < 25) check($sformatf("drift%0d.y", k), int'(ay), jump_y(k));
    end
    check_all("drift_land", 278, 300, 0, 0);
    step(K_0, 1'b1);
    check_all("drift_after", 278, 300, 0, 0);

    // hp_zero on tick 10 of a jump: death, ballistic landing, then terminal
    for (int k = 1; k <= 25; k++) begin
      step((k == 1) ? K_U : ((k == 10) ? K_H : (K_R | K_U)), 1'b1);
      if (k < 10)      check($sformatf("die%0d.sprite", k), int'(spr), 2);
      else if (k < 25) check_all($sformatf("die%0d", k), 278, jump_y(k), 6, 1);
      else             check_all("die_land", 278, 300, 6, 0);
    end
    for (int k = 0; k < 3; k++) begin
      step(K_U | K_L | K_P, 1'b1);
      check_all($sformatf("dead%0d", k), 278, 300, 6, 0);
    end
    reset_and_check("rst_dead");

    // Reset mid-jump leaves no residual velocity
    step(K_U, 1'b1);
    step(K_0, 1'b1);
    step(K_0, 1'b1);
    check("midjump.y", int'(ay), jump_y(3));
    reset_and_check("rst_jump");
    step(K_0, 1'b1);
    check_all("after_rst_jump", 320, 300, 0, 0);
    step(K_U, 1'b1);
    check_all("rejump", 320, 288, 2, 1);

    // Reset mid-punch leaves no residual counter
    reset_and_check("rst_pre_punch");
    step(K_P, 1'b1);
    step(K_0, 1'b1);
    check("midpunch.sprite", int'(spr), 1);
    reset_and_check("rst_punch");
    step(K_L, 1'b1);
    check_all("after_rst_punch", 318, 300, 4, 0);

    // Death from the ground freezes everything
    step(K_H, 1'b1);
    check_all("gdeath", 318, 300, 6, 0);
    step(K_U | K_R, 1'b1);
    check_all("gdeath_keys", 318, 300, 6, 0);
    step(K_0, 1'b1);
    check_all("gdeath_hplow", 318, 300, 6, 0);

    // X saturation at both screen edges
    reset_and_check("rst_clamp_lo");
    for (int k = 1; k <= 3; k++) begin
      step(K_L, 1'b1);
      check($sformatf("clamp_lo%0d.x", k), int'(lo_x), 0);
      check($sformatf("clamp_lo%0d.sprite", k), int'(lo_spr), 4);
    end
    reset_and_check("rst_clamp_hi");
    for (int k = 1; k <= 2; k++) begin
      step(K_R, 1'b1);
      check($sformatf("clamp_hi%0d.x", k), int'(hi_x), 560);
      check($sformatf("clamp_hi%0d.sprite", k), int'(hi_spr), 5);
      check($sformatf("lo_right%0d.x", k), int'(lo_x), 1 + 2 * k);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/akuma_motion.md
Name: akuma_motion

Overview:
Frame-rate character controller for Akuma; sits directly upstream of the sprite selector and produces its AkumaX, AkumaY and 3-bit sprite code. Samples player control levels once per frame tick and runs an 8-state action FSM covering walking, jumping with gravity, timed punches, jump attacks and death. All outputs are registered and held between ticks, so the renderer sees stable values for the whole frame.

Parameters:
X_START, 320, reset X position in pixels
X_MIN, 0, leftmost legal AkumaX
X_MAX, 560, rightmost legal AkumaX (640 minus sprite width)
GROUND_Y, 300, resting AkumaY
WALK_STEP, 2, pixels moved per tick while walking or airborne-with-drift
JUMP_VEL, 12, initial upward speed in px/tick
GRAVITY, 1, vy increment per tick
PUNCH_FRAMES, 8, ticks a ground punch lasts

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
frame_tick  in  1  one-Clk pulse per video frame (vsync edge)
key_left  in  1  level, move left
key_right  in  1  level, move right
key_up  in  1  level, jump
key_down  in  1  level, crouch
key_punch  in  1  level, attack
hp_zero  in  1  level, health exhausted
AkumaX  out  10  sprite left edge
AkumaY  out  10  sprite top edge
sprite  out  3  0 stand, 1 punch, 2 jump, 3 crouch, 4 walk left, 5 walk right, 6 death, 7 jump attack
airborne  out  1  high while Y is above ground or still rising

Behaviour:
- Reset (async, Reset_n low): state STAND, AkumaX=X_START, AkumaY=GROUND_Y, sprite=0, vy=0, drift=0, punch counter=0, airborne=0.
- All state changes occur only on Clk edges where frame_tick=1; outputs update in that cycle's register and are visible the next Clk. No change at any other cycle.
- sprite always equals the state encoding above.
- Ground-state decision priority per tick: hp_zero > key_up > key_punch > key_down > horizontal keys > none.
  - key_up: JUMP; vy=-JUMP_VEL; drift=-1/+1/0 from left-only/right-only/else; first motion applied same tick.
  - key_punch: PUNCH, counter=PUNCH_FRAMES-1; X,Y frozen.
  - key_down: CROUCH; X frozen; leaves when key_down low.
  - left-only: WALK_L, X-=WALK_STEP; right-only: WALK_R, X+=WALK_STEP; both or neither: STAND.
- PUNCH is non-interruptible except by hp_zero; counter decrements each tick; at 0, next tick re-evaluates ground priority.
- JUMP/JATK each tick: Y_next = Y + vy (signed, 11-bit minimum internal width); vy += GRAVITY; X += drift*WALK_STEP. If Y_next >= GROUND_Y and vy was >= 0: Y=GROUND_Y, state STAND, airborne=0, same tick. key_punch in JUMP -> JATK (sticky until landing). Keys other than punch ignored while airborne.
- X clamped to [X_MIN, X_MAX] every tick; clamping never underflows (compute signed, then saturate).
- hp_zero: enter DEATH at next tick from any state; if airborne, ballistic motion continues until landing, then Y fixed at GROUND_Y; DEATH is terminal until reset. All keys ignored.
- Reset mid-jump or mid-punch returns immediately to reset values; no residual vy or counter.

Decomposition:
- Shared package akuma_pkg: enum akuma_state_t (values 0..7 matching sprite codes), SCREEN_W=640, SCREEN_H=480, sprite code constants reused by the sprite selector.
- One natural sub-module: akuma_physics (combinational signed Y/vy/X update with landing detect and X saturation); FSM and registers stay in akuma_motion.

Test Plan:
- Reset with default parameters -> X=320, Y=300, sprite=0, airborne=0; keys without frame_tick change nothing.
- key_right held 5 ticks -> X=330, sprite=5; release -> next tick sprite=0, X=330.
- key_up one tick from rest -> Y=288 after tick 1, 277 after tick 2, returns to Y=300 with sprite=0 exactly on tick 25; airborne high ticks 1-24.
- key_punch one tick -> sprite=1 for exactly 8 ticks, X/Y unchanged; key_left held during punch ignored until tick 9.
- From X=1, key_left 3 ticks -> X=0 and held at 0; from X=559 key_right -> saturates at 560.
- Mid-jump (tick 5) assert key_punch -> sprite=7 until landing at tick 25, then 0; assert hp_zero at tick 10 of a jump -> sprite=6, lands Y=300, remains 6 with all keys ignored until Reset_n low.
